// File: rtl/pe_pad_ctrl_pkg.sv
// rtl/pe_pad_ctrl_pkg.sv - shared types and widths for the PE pad sequencer
package pe_pad_ctrl_pkg;

  localparam int CONF_DWD  = 4;  // IFLen, PopU, Tm field width
  localparam int PCONF_DWD = 3;  // Pch field width
  localparam int TW_WD     = 6;  // Tw, Th field width

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_CLR   = 4'd1,
    ST_START = 4'd2,
    ST_RUN   = 4'd3,
    ST_POP   = 4'd4,
    ST_ROW   = 4'd5,
    ST_DONE  = 4'd6
  } pe_ctrl_state_e;

  // All fields hold count-1
  typedef struct packed {
    logic [CONF_DWD-1:0]  iflen;
    logic [CONF_DWD-1:0]  popu;
    logic [PCONF_DWD-1:0] pch;
    logic [CONF_DWD-1:0]  tm;
    logic [TW_WD-1:0]     tw;
    logic [TW_WD-1:0]     th;
  } pe_tile_cfg_t;

endpackage

// File: rtl/pe_loop_cnt.sv
// rtl/pe_loop_cnt.sv - wrapping loop counter, wraps to 0 after reaching i_max
module pe_loop_cnt #(
  parameter int W = 4
) (
  input  logic         i_clk,
  input  logic         i_rstn,
  input  logic         i_clr,
  input  logic         i_inc,
  input  logic [W-1:0] i_max,
  output logic         o_wrap
);

  logic [W-1:0] cnt_q, cnt_d;

  // Wrap is flagged on the increment that leaves the terminal count
  assign o_wrap = i_inc && (cnt_q == i_max);

  // Next count: clear wins over increment
  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (i_inc) begin
      cnt_d = (cnt_q == i_max) ? '0 : cnt_q + 1'b1;
    end
  end

  // Count register
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/pe_pad_ctrl.sv
// rtl/pe_pad_ctrl.sv - per-PE IFPAD/WPAD sequencer (optional abort: PE_CTRL_ABORT_EN)
module pe_pad_ctrl
  import pe_pad_ctrl_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rstn,
`ifdef PE_CTRL_ABORT_EN
  input  logic                 i_abort,
`endif
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [CONF_DWD-1:0]  cfg_iflen,
  input  logic [CONF_DWD-1:0]  cfg_popu,
  input  logic [CONF_DWD-1:0]  cfg_tm,
  input  logic [PCONF_DWD-1:0] cfg_pch,
  input  logic [TW_WD-1:0]     cfg_tw,
  input  logic [TW_WD-1:0]     cfg_th,
  input  logic                 mac_fire,
  input  logic                 psum_stall,
  output logic [CONF_DWD-1:0]  o_iflen,
  output logic [CONF_DWD-1:0]  o_popu,
  output logic [PCONF_DWD-1:0] o_pch,
  output logic                 o_pop,
  output logic                 o_nxtrow,
  output logic                 o_nxtwrow,
  output logic                 o_start,
  output logic                 o_reset,
  output logic                 o_done,
  output logic                 o_stall,
  output logic                 o_busy
);

  pe_ctrl_state_e state_q, state_d;
  pe_tile_cfg_t   cfg_q, cfg_d;

  logic run_fire, cnt_clr;
  logic k_wrap, m_wrap, w_wrap, r_wrap;
  logic abort_req, clr_to_idle;

`ifdef PE_CTRL_ABORT_EN
  logic abort_q, abort_d;

  assign abort_req   = i_abort && (state_q != ST_IDLE) && (state_q != ST_CLR);
  assign clr_to_idle = abort_q;

  // Remember that the current CLR pass came from an abort
  always_comb begin
    abort_d = abort_q;
    if (abort_req)                abort_d = 1'b1;
    else if (state_q == ST_CLR)   abort_d = 1'b0;
  end

  // Abort flag register
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) abort_q <= 1'b0;
    else         abort_q <= abort_d;
  end
`else
  assign abort_req   = 1'b0;
  assign clr_to_idle = 1'b0;
`endif

  // Only unstalled fires in RUN advance the loop nest
  assign run_fire = (state_q == ST_RUN) && mac_fire && !psum_stall;
  assign cnt_clr  = (state_q == ST_IDLE) || (state_q == ST_CLR);

  pe_loop_cnt #(.W(CONF_DWD)) u_k_cnt (
    .i_clk (i_clk), .i_rstn (i_rstn), .i_clr (cnt_clr),
    .i_inc (run_fire), .i_max (cfg_q.iflen), .o_wrap (k_wrap)
  );

  pe_loop_cnt #(.W(CONF_DWD)) u_m_cnt (
    .i_clk (i_clk), .i_rstn (i_rstn), .i_clr (cnt_clr),
    .i_inc (k_wrap), .i_max (cfg_q.tm), .o_wrap (m_wrap)
  );

  pe_loop_cnt #(.W(TW_WD)) u_w_cnt (
    .i_clk (i_clk), .i_rstn (i_rstn), .i_clr (cnt_clr),
    .i_inc (state_q == ST_POP), .i_max (cfg_q.tw), .o_wrap (w_wrap)
  );

  pe_loop_cnt #(.W(TW_WD)) u_r_cnt (
    .i_clk (i_clk), .i_rstn (i_rstn), .i_clr (cnt_clr),
    .i_inc (state_q == ST_ROW), .i_max (cfg_q.th), .o_wrap (r_wrap)
  );

  // Next-state and config latch; abort overrides any natural transition
  always_comb begin
    state_d = state_q;
    cfg_d   = cfg_q;
    case (state_q)
      ST_IDLE: begin
        if (cfg_valid) begin
          cfg_d.iflen = cfg_iflen;
          cfg_d.popu  = cfg_popu;
          cfg_d.pch   = cfg_pch;
          cfg_d.tm    = cfg_tm;
          cfg_d.tw    = cfg_tw;
          cfg_d.th    = cfg_th;
          state_d     = ST_CLR;
        end
      end
      ST_CLR:   state_d = clr_to_idle ? ST_IDLE : ST_START;
      ST_START: state_d = ST_RUN;
      ST_RUN:   if (m_wrap) state_d = ST_POP;
      ST_POP:   state_d = w_wrap ? ST_ROW : ST_RUN;
      ST_ROW:   state_d = r_wrap ? ST_DONE : ST_RUN;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (abort_req) state_d = ST_CLR;
  end

  // State and latched config registers
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= ST_IDLE;
      cfg_q   <= '0;
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_d;
    end
  end

  assign cfg_ready = (state_q == ST_IDLE);
  assign o_busy    = (state_q != ST_IDLE);
  assign o_reset   = (state_q == ST_CLR);
  assign o_start   = (state_q == ST_START);
  assign o_pop     = (state_q == ST_POP);
  assign o_nxtrow  = (state_q == ST_ROW);
  assign o_nxtwrow = (state_q == ST_ROW);
  assign o_done    = (state_q == ST_DONE);
  // Pads are frozen throughout a tile except in unstalled RUN cycles
  assign o_stall   = o_busy && ((state_q != ST_RUN) || psum_stall);
  assign o_iflen   = cfg_q.iflen;
  assign o_popu    = cfg_q.popu;
  assign o_pch     = cfg_q.pch;

endmodule
